pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Pipelined successor to the combinational MIPS decoder.
- Decodes op/func in ID and registers the control bundle (muxctrl/memctrl/aluctrl) through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds a load-use interlock, branch/jump flush and EX operand-forwarding selects.
- Sits beside the datapath pipeline registers; the datapath consumes per-stage control outputs.

Parameters:
- REG_AW, 5, register-address width.
- ALU_W, 5, aluctrl width.
- MUX_W, 7, muxctrl width (bit map below; must be ≥7).
- LOAD_INTERLOCK, 1, 1 = load-use stall enabled; 0 = no stall, software schedules loads.
- FWD_EN, 1, 1 = forwarding selects active; 0 = fwd_a/fwd_b forced to 00.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  6  ID-stage opcode
- func  in  6  ID-stage function field
- rs  in  REG_AW  ID-stage source 1
- rt  in  REG_AW  ID-stage source 2
- rd  in  REG_AW  ID-stage R-type destination
- zero  in  1  ALU zero flag of the EX-stage instruction
- id_jump  out  1  ID holds J or JR (combinational)
- stall  out  1  hold PC and IF/ID (combinational)
- flush  out  1  kill IF/ID (combinational)
- ex_muxctrl  out  MUX_W  ID/EX muxctrl
- ex_aluctrl  out  ALU_W  ID/EX aluctrl
- ex_memctrl  out  3  ID/EX memctrl
- mem_memctrl  out  3  EX/MEM memctrl
- wb_memctrl  out  3  MEM/WB memctrl (bit0 = regfile write)
- wb_mem_to_reg  out  1  MEM/WB muxctrl bit1
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high (reset).
- memctrl bits: 0 reg write, 1 mem write, 2 mem read.
- muxctrl bits: 0 ALU_src, 1 mem_to_reg, [3:2] dest select (00 rd, 01 rt), 4 bubble marker, 5 shamt select, 6 jump.
- aluctrl codes: AND 00000, OR 00001, add 00010, sub 00110, passB 00111, NOR 01100, SLL 01101, SRL 01110, SRA 01111, SLT 10000, SLE 10001.
- R-type decode (op 000000), each with memctrl 001:
  - ADD 100000 / ADDU 100001 → add.
  - SUB 100010 / SUBU 100011 → sub.
  - AND 100100, OR 100101, NOR 100111, SLT 101010.
  - SLL 000000, SRL 000010, SRA 000011: muxctrl bit5 = 1.
  - JR 001000: muxctrl bit6 = 1, memctrl 000.
- I/J-type decode:
  - LW 100011: muxctrl bits 0,1 set, dest rt, memctrl 101, add.
  - SW 101011: ALU_src, memctrl 010, add.
  - ADDI 001000: ALU_src, dest rt, memctrl 001, add.
  - BEQ 000100 / BNE 000101: sub, memctrl 000.
  - J 000010: bit6.
- Unknown op/func decodes as NOP: all zero, aluctrl 01101.
- Bubble word: muxctrl = bit4 only, memctrl 000, aluctrl 00000.
- Reset: all registered stages load the bubble word with bit4 = 0, i.e. all zero. fwd 00; stall, flush 0 while reset is high.
- Each stage register tracks its destination register (the resolved rd or rt) and a branch type (none/BEQ/BNE).
- Latency: decode→ex_* 1 cycle, →mem_memctrl 2, →wb_* 3.
- Load-use:
  - Condition: ex_memctrl bit2, ex dest ≠ 0, and ex dest == rs or rt.
  - Response: stall = 1, and ID/EX loads the bubble. The instruction in ID is re-decoded next cycle, giving exactly one stall cycle.
- Branch taken:
  - Condition: EX is BEQ with zero = 1, or BNE with zero = 0.
  - Response: flush = 1, and ID/EX loads the bubble on the next edge.
- Jump: id_jump = 1 means the IF/ID slot is killed by the upstream logic. The jump itself proceeds.
- Priority: reset > branch flush > load-use stall > normal. When a flush and a stall occur together, stall = 0 and a bubble is issued; the wrong-path instruction in ID is discarded.
- Forwarding (FWD_EN = 1):
  - fwd_a = 01 if EX/MEM regwrite and dest ≠ 0 and dest == ID/EX rs.
  - Else fwd_a = 10 if the MEM/WB condition holds.
  - Else fwd_a = 00.
  - fwd_b is the same rule applied to ID/EX rt.
  - The EX/MEM match wins when both match.
- Register $0 never causes a hazard or a forward.
- Reset mid-stall: the next edge clears all stages. Stall deasserts in the same cycle that reset is sampled high.

Decomposition:
- ctrl_pkg holds:
  - opcode/func constants;
  - aluctrl codes;
  - muxctrl/memctrl bit indices;
  - BUBBLE/NOP control words;
  - branch-type encoding.
- Sub-module hazard_unit: combinational stall/flush/fwd_a/fwd_b from the stage dest/regwrite/memread/branch fields.
- pipe_controller holds the decoder and the three stage registers.

Test Plan:
- Reset high 2 cycles with op = ADD → all ex/mem/wb outputs 0, stall 0; first ADD appears at ex_aluctrl = 00010 one cycle after reset drops.
- LW r2 then ADD r3,r2,r4 → stall = 1 for exactly 1 cycle, ex_muxctrl = 0010000 bubble; ADD then issues with fwd_a = 10.
- ADD r5,r1,r1 then SUB r6,r5,r5 → fwd_a = fwd_b = 01 in SUB's EX cycle, no stall.
- BEQ with zero = 1 in EX while ID holds LW-dependent ADD → flush = 1, stall = 0, bubble enters ID/EX; BNE with zero = 1 → no flush.
- Writes to r0 (ADD r0,…) followed by a reader of r0 → fwd 00, no stall; J op 000010 → id_jump = 1, ex_muxctrl bit6 set next cycle.
- LOAD_INTERLOCK = 0, FWD_EN = 0 build: LW→use sequence → stall never asserts, fwd_a/fwd_b constant 00.

Source files
------------

// File: rtl/pipe_controller_pkg.sv
// pipe_controller_pkg: opcode/func constants, control-word layout and the ID-stage decode table.
package pipe_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [4:0] ALU_AND   = 5'b00000;
    localparam logic [4:0] ALU_OR    = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_SUB   = 5'b00110;
    localparam logic [4:0] ALU_PASSB = 5'b00111;
    localparam logic [4:0] ALU_NOR   = 5'b01100;
    localparam logic [4:0] ALU_SLL   = 5'b01101;
    localparam logic [4:0] ALU_SRL   = 5'b01110;
    localparam logic [4:0] ALU_SRA   = 5'b01111;
    localparam logic [4:0] ALU_SLT   = 5'b10000;
    localparam logic [4:0] ALU_SLE   = 5'b10001;

    localparam int MUX_ALUSRC = 0;
    localparam int MUX_MEM2REG = 1;
    localparam int MUX_DST = 2;
    localparam int MUX_BUBBLE = 4;
    localparam int MUX_SHAMT = 5;
    localparam int MUX_JUMP = 6;

    localparam int MEM_REGWR = 0;
    localparam int MEM_MEMWR = 1;
    localparam int MEM_MEMRD = 2;

    typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE} br_t;

    typedef struct packed {
        logic [6:0] mux;
        logic [2:0] mem;
        logic [4:0] alu;
        br_t        br;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{7'b0010000, 3'b000, ALU_AND, BR_NONE};
    localparam ctrl_t NOP    = '{7'b0000000, 3'b000, ALU_SLL, BR_NONE};

    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] func);
        ctrl_t c;
        c = NOP;
        if (op == OP_RTYPE)
            case (func)
                FN_ADD, FN_ADDU: c = '{7'b0000000, 3'b001, ALU_ADD, BR_NONE};
                FN_SUB, FN_SUBU: c = '{7'b0000000, 3'b001, ALU_SUB, BR_NONE};
                FN_AND:          c = '{7'b0000000, 3'b001, ALU_AND, BR_NONE};
                FN_OR:           c = '{7'b0000000, 3'b001, ALU_OR, BR_NONE};
                FN_NOR:          c = '{7'b0000000, 3'b001, ALU_NOR, BR_NONE};
                FN_SLT:          c = '{7'b0000000, 3'b001, ALU_SLT, BR_NONE};
                FN_SLL:          c = '{7'b0100000, 3'b001, ALU_SLL, BR_NONE};
                FN_SRL:          c = '{7'b0100000, 3'b001, ALU_SRL, BR_NONE};
                FN_SRA:          c = '{7'b0100000, 3'b001, ALU_SRA, BR_NONE};
                FN_JR:           c = '{7'b1000000, 3'b000, ALU_AND, BR_NONE};
                default:         c = NOP;
            endcase
        else
            case (op)
                OP_LW:   c = '{7'b0000111, 3'b101, ALU_ADD, BR_NONE};
                OP_SW:   c = '{7'b0000001, 3'b010, ALU_ADD, BR_NONE};
                OP_ADDI: c = '{7'b0000101, 3'b001, ALU_ADD, BR_NONE};
                OP_BEQ:  c = '{7'b0000000, 3'b000, ALU_SUB, BR_BEQ};
                OP_BNE:  c = '{7'b0000000, 3'b000, ALU_SUB, BR_BNE};
                OP_J:    c = '{7'b1000000, 3'b000, ALU_AND, BR_NONE};
                default: c = NOP;
            endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_controller_hazard_unit.sv
// hazard_unit: load-use stall, taken-branch flush and EX operand-forwarding selects.
module hazard_unit
    import pipe_controller_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LOAD_INTERLOCK = 1,
    parameter int FWD_EN = 1
) (
    input  logic              reset,
    input  logic              zero,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_memread,
    input  br_t               ex_br,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_regwrite,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    logic load_use;

    // the nearer (EX/MEM) producer holds the newer value, so it is tested first
    function automatic logic [1:0] src(input logic [REG_AW-1:0] r, input logic mw, input logic [REG_AW-1:0] md,
                                       input logic ww, input logic [REG_AW-1:0] wd);
        return r == '0 ? 2'b00 : (mw && md == r) ? 2'b01 : (ww && wd == r) ? 2'b10 : 2'b00;
    endfunction

    assign flush = !reset && ((ex_br == BR_BEQ && zero) || (ex_br == BR_BNE && !zero));
    assign load_use = ex_memread && ex_dest != '0 && (ex_dest == id_rs || ex_dest == id_rt);
    assign stall = LOAD_INTERLOCK != 0 && !reset && !flush && load_use;
    assign fwd_a = (FWD_EN != 0 && !reset) ? src(ex_rs, mem_regwrite, mem_dest, wb_regwrite, wb_dest) : 2'b00;
    assign fwd_b = (FWD_EN != 0 && !reset) ? src(ex_rt, mem_regwrite, mem_dest, wb_regwrite, wb_dest) : 2'b00;
endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: ID-stage decoder plus the ID/EX, EX/MEM and MEM/WB control registers.
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int ALU_W = 5,
    parameter int MUX_W = 7,
    parameter int LOAD_INTERLOCK = 1,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              zero,
    output logic              id_jump,
    output logic              stall,
    output logic              flush,
    output logic [MUX_W-1:0]  ex_muxctrl,
    output logic [ALU_W-1:0]  ex_aluctrl,
    output logic [2:0]        ex_memctrl,
    output logic [2:0]        mem_memctrl,
    output logic [2:0]        wb_memctrl,
    output logic              wb_mem_to_reg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    ctrl_t             dec, ex_c;
    logic [REG_AW-1:0] id_dest, ex_dest, ex_rs, ex_rt, mem_dest, wb_dest;
    logic              mem_m2r, bubble;

    assign dec = decode(op, func);
    assign id_dest = dec.mux[MUX_DST +: 2] == 2'b01 ? rt : rd;
    assign id_jump = dec.mux[MUX_JUMP];
    assign bubble = stall || flush;

    assign ex_muxctrl = MUX_W'(ex_c.mux);
    assign ex_aluctrl = ALU_W'(ex_c.alu);
    assign ex_memctrl = ex_c.mem;

    hazard_unit #(.REG_AW(REG_AW), .LOAD_INTERLOCK(LOAD_INTERLOCK), .FWD_EN(FWD_EN)) u_hazard (
        .reset(reset),
        .zero(zero),
        .id_rs(rs),
        .id_rt(rt),
        .ex_rs(ex_rs),
        .ex_rt(ex_rt),
        .ex_dest(ex_dest),
        .ex_memread(ex_c.mem[MEM_MEMRD]),
        .ex_br(ex_c.br),
        .mem_dest(mem_dest),
        .mem_regwrite(mem_memctrl[MEM_REGWR]),
        .wb_dest(wb_dest),
        .wb_regwrite(wb_memctrl[MEM_REGWR]),
        .stall(stall),
        .flush(flush),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b)
    );

    // a bubble carries no register fields so it can never match a hazard or forward
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_c <= '0;
            ex_dest <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            mem_memctrl <= '0;
            mem_m2r <= 1'b0;
            mem_dest <= '0;
            wb_memctrl <= '0;
            wb_mem_to_reg <= 1'b0;
            wb_dest <= '0;
        end else begin
            ex_c <= bubble ? BUBBLE : dec;
            ex_dest <= bubble ? '0 : id_dest;
            ex_rs <= bubble ? '0 : rs;
            ex_rt <= bubble ? '0 : rt;
            mem_memctrl <= ex_c.mem;
            mem_m2r <= ex_c.mux[MUX_MEM2REG];
            mem_dest <= ex_dest;
            wb_memctrl <= mem_memctrl;
            wb_mem_to_reg <= mem_m2r;
            wb_dest <= mem_dest;
        end
    end
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: two builds (interlock+forwarding, and neither) against a per-cycle pipeline model.
module tb_pipe_controller;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;

    typedef struct packed {
        logic [6:0] mux;
        logic [2:0] mem;
        logic [4:0] alu;
        logic [1:0] br;
        logic [4:0] dest, rs, rt;
    } st_t;

    logic clk = 0, reset = 1, zero = 0;
    logic [5:0] op = R, func = F_ADD;
    logic [4:0] rs = 0, rt = 0, rd = 0;
    logic       jmp [2], stl [2], fls [2], m2r [2];
    logic [6:0] exm [2];
    logic [4:0] exa [2];
    logic [2:0] exmem [2], memm [2], wbm [2];
    logic [1:0] fa [2], fb [2];
    st_t ex_s [2], mem_s [2], wb_s [2], nex [2], nmem [2], nwb [2];
    int checks = 0, errors = 0;
    bit live = 0;

    always #5 clk = ~clk;

    pipe_controller u0 (.clk(clk), .reset(reset), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .zero(zero),
        .id_jump(jmp[0]), .stall(stl[0]), .flush(fls[0]), .ex_muxctrl(exm[0]), .ex_aluctrl(exa[0]),
        .ex_memctrl(exmem[0]), .mem_memctrl(memm[0]), .wb_memctrl(wbm[0]), .wb_mem_to_reg(m2r[0]),
        .fwd_a(fa[0]), .fwd_b(fb[0]));

    pipe_controller #(.LOAD_INTERLOCK(0), .FWD_EN(0)) u1 (.clk(clk), .reset(reset), .op(op), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .zero(zero),
        .id_jump(jmp[1]), .stall(stl[1]), .flush(fls[1]), .ex_muxctrl(exm[1]), .ex_aluctrl(exa[1]),
        .ex_memctrl(exmem[1]), .mem_memctrl(memm[1]), .wb_memctrl(wbm[1]), .wb_mem_to_reg(m2r[1]),
        .fwd_a(fa[1]), .fwd_b(fb[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic st_t mk(input logic [6:0] mux, input logic [2:0] mem, input logic [4:0] alu,
                               input logic [1:0] br, input logic [4:0] s, t, d);
        st_t x;
        x.mux = mux; x.mem = mem; x.alu = alu; x.br = br; x.rs = s; x.rt = t;
        x.dest = mux[3:2] == 2'b01 ? t : d;
        return x;
    endfunction

    function automatic st_t spec_dec(input logic [5:0] o, f, input logic [4:0] s, t, d);
        if (o == R)
            case (f)
                6'b100000, 6'b100001: return mk(7'b0000000, 3'b001, 5'b00010, 0, s, t, d);
                6'b100010, 6'b100011: return mk(7'b0000000, 3'b001, 5'b00110, 0, s, t, d);
                6'b100100: return mk(7'b0000000, 3'b001, 5'b00000, 0, s, t, d);
                6'b100101: return mk(7'b0000000, 3'b001, 5'b00001, 0, s, t, d);
                6'b100111: return mk(7'b0000000, 3'b001, 5'b01100, 0, s, t, d);
                6'b101010: return mk(7'b0000000, 3'b001, 5'b10000, 0, s, t, d);
                6'b000000: return mk(7'b0100000, 3'b001, 5'b01101, 0, s, t, d);
                6'b000010: return mk(7'b0100000, 3'b001, 5'b01110, 0, s, t, d);
                6'b000011: return mk(7'b0100000, 3'b001, 5'b01111, 0, s, t, d);
                6'b001000: return mk(7'b1000000, 3'b000, 5'b00000, 0, s, t, d);
                default:   return mk(7'b0000000, 3'b000, 5'b01101, 0, s, t, d);
            endcase
        case (o)
            LW:      return mk(7'b0000111, 3'b101, 5'b00010, 0, s, t, d);
            SW:      return mk(7'b0000001, 3'b010, 5'b00010, 0, s, t, d);
            ADDI:    return mk(7'b0000101, 3'b001, 5'b00010, 0, s, t, d);
            BEQ:     return mk(7'b0000000, 3'b000, 5'b00110, 1, s, t, d);
            BNE:     return mk(7'b0000000, 3'b000, 5'b00110, 2, s, t, d);
            J:       return mk(7'b1000000, 3'b000, 5'b00000, 0, s, t, d);
            default: return mk(7'b0000000, 3'b000, 5'b01101, 0, s, t, d);
        endcase
    endfunction

    function automatic logic [1:0] fw(input int c, input logic [4:0] r);
        if (c == 1 || reset || r == 0) return 2'b00;
        if (mem_s[c].mem[0] && mem_s[c].dest == r) return 2'b01;
        if (wb_s[c].mem[0] && wb_s[c].dest == r) return 2'b10;
        return 2'b00;
    endfunction

    // model: compare at the negedge, advance at the posedge
    initial begin
        st_t bub;
        bub = '0;
        bub.mux = 7'b0010000;
        for (int c = 0; c < 2; c++) begin ex_s[c] = '0; mem_s[c] = '0; wb_s[c] = '0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                logic ef, es;
                ef = !reset && ((ex_s[c].br == 1 && zero) || (ex_s[c].br == 2 && !zero));
                es = c == 0 && !reset && !ef && ex_s[c].mem[2] && ex_s[c].dest != 0 &&
                     (ex_s[c].dest == rs || ex_s[c].dest == rt);
                if (live) begin
                    chk($sformatf("id_jump%0d", c), jmp[c], (op == J) || (op == R && func == 6'b001000));
                    chk($sformatf("flush%0d", c), fls[c], ef);
                    chk($sformatf("stall%0d", c), stl[c], es);
                    chk($sformatf("ex_muxctrl%0d", c), exm[c], ex_s[c].mux);
                    chk($sformatf("ex_aluctrl%0d", c), exa[c], ex_s[c].alu);
                    chk($sformatf("ex_memctrl%0d", c), exmem[c], ex_s[c].mem);
                    chk($sformatf("mem_memctrl%0d", c), memm[c], mem_s[c].mem);
                    chk($sformatf("wb_memctrl%0d", c), wbm[c], wb_s[c].mem);
                    chk($sformatf("wb_mem_to_reg%0d", c), m2r[c], wb_s[c].mux[1]);
                    chk($sformatf("fwd_a%0d", c), fa[c], fw(c, ex_s[c].rs));
                    chk($sformatf("fwd_b%0d", c), fb[c], fw(c, ex_s[c].rt));
                end
                nwb[c] = reset ? '0 : mem_s[c];
                nmem[c] = reset ? '0 : ex_s[c];
                nex[c] = reset ? '0 : (ef || es) ? bub : spec_dec(op, func, rs, rt, rd);
            end
            if (reset) live = 1;
            @(posedge clk);
            for (int c = 0; c < 2; c++) begin ex_s[c] = nex[c]; mem_s[c] = nmem[c]; wb_s[c] = nwb[c]; end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] o, f, input logic [4:0] s, t, d, input logic z);
        @(posedge clk);
        #1;
        reset = r; op = o; func = f; rs = s; rt = t; rd = d; zero = z;
        #1;
    endtask

    initial begin
        logic [5:0] ops [18], fns [18];
        ops = '{R, R, R, R, R, R, R, R, R, R, R, R, LW, SW, ADDI, BEQ, BNE, J};
        fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                6'b000000, 6'b000010, 6'b000011, 6'b001000, 0, 0, 0, 0, 0, 0};
        cyc(1, R, F_ADD, 1, 1, 1, 0);
        cyc(1, R, F_ADD, 1, 1, 1, 0);
        chk("reset_alu", exa[0], 5'b00000);
        chk("reset_mux", exm[0], 7'b0000000);
        chk("reset_stall", stl[0], 1'b0);
        cyc(0, R, F_ADD, 2, 3, 1, 0);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("first_add_alu", exa[0], 5'b00010);
        cyc(0, LW, 0, 1, 2, 0, 0);
        cyc(0, R, F_ADD, 2, 4, 3, 0);
        chk("loaduse_stall", stl[0], 1'b1);
        chk("loaduse_nointerlock", stl[1], 1'b0);
        cyc(0, R, F_ADD, 2, 4, 3, 0);
        chk("loaduse_one_cycle", stl[0], 1'b0);
        chk("loaduse_bubble", exm[0], 7'b0010000);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("loaduse_fwd_wb", fa[0], 2'b10);
        chk("nofwd_build", fa[1], 2'b00);
        cyc(0, R, F_ADD, 1, 1, 5, 0);
        cyc(0, R, F_SUB, 5, 5, 6, 0);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("fwd_a_mem", fa[0], 2'b01);
        chk("fwd_b_mem", fb[0], 2'b01);
        chk("fwd_no_stall", stl[0], 1'b0);
        cyc(0, BEQ, 0, 1, 1, 0, 0);
        cyc(0, R, F_ADD, 7, 7, 8, 1);
        chk("beq_flush", fls[0], 1'b1);
        chk("beq_no_stall", stl[0], 1'b0);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("flush_bubble", exm[0], 7'b0010000);
        cyc(0, BNE, 0, 1, 2, 0, 0);
        cyc(0, BAD, 0, 0, 0, 0, 1);
        chk("bne_zero_no_flush", fls[0], 1'b0);
        cyc(0, R, F_ADD, 1, 1, 0, 0);
        cyc(0, R, F_ADD, 0, 0, 8, 0);
        cyc(0, LW, 0, 1, 0, 0, 0);
        chk("r0_fwd_a", fa[0], 2'b00);
        chk("r0_fwd_b", fb[0], 2'b00);
        cyc(0, R, F_ADD, 0, 0, 9, 0);
        chk("r0_no_stall", stl[0], 1'b0);
        cyc(0, J, 0, 0, 0, 0, 0);
        chk("j_id_jump", jmp[0], 1'b1);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("j_ex_mux", exm[0], 7'b1000000);
        cyc(0, LW, 0, 1, 3, 0, 0);
        cyc(1, R, F_ADD, 3, 1, 4, 0);
        chk("reset_kills_stall", stl[0], 1'b0);
        cyc(0, BAD, 0, 0, 0, 0, 0);
        chk("reset_mid_stall_clear", exm[0], 7'b0000000);
        for (int i = 0; i < 1500; i++) begin
            int k;
            k = $urandom_range(0, 18);
            cyc($urandom_range(0, 49) == 0, k == 18 ? 6'($urandom) : ops[k], k == 18 ? 6'($urandom) : fns[k],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
        end
        cyc(0, BAD, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
